cmp_sweep_driver: RTL and testbench

- Sequential stimulus/response end of the 8-bit magnitude-comparator interface (din_a, din_b -> comp_equal, comp_greater).
- Sweeps every operand pair from (0,0) to (a_limit,b_limit) onto the comparator inputs and samples the comparator flags.
- Emits one classified result record per pair over a valid/ready stream and keeps running EQ/GT/LT tallies.
- Used for on-chip self-test of comparator instances and as a reusable bench driver.

---
 rtl/cmp_pkg.sv | 26 ++
 rtl/cmp_tally.sv | 35 +++
 rtl/cmp_sweep_driver.sv | 116 +++++++++++
 tb/tb_cmp_sweep_driver.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: shared widths, result codes and sweep FSM states for the comparator sweep driver
package cmp_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        RES_LT  = 2'b00,
        RES_EQ  = 2'b01,
        RES_GT  = 2'b10,
        RES_ERR = 2'b11
    } res_code_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SAMPLE,
        S_EMIT,
        S_DONE
    } sweep_state_t;

    // The code encoding is {gt, eq}, so both flags set lands on RES_ERR naturally
    function automatic res_code_t classify(input logic eq, input logic gt);
        return res_code_t'({gt, eq});
    endfunction

endpackage

// File: rtl/cmp_tally.sv
// cmp_tally: four result tallies with synchronous clear and one-hot increment (bit index = result code)
module cmp_tally #(
    parameter int CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic [3:0]       inc,
    output logic [CNT_W-1:0] cnt_eq,
    output logic [CNT_W-1:0] cnt_gt,
    output logic [CNT_W-1:0] cnt_lt,
    output logic [CNT_W-1:0] cnt_err
);

    // Counters clear on a new sweep and bump the one selected by inc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_eq  <= '0;
            cnt_gt  <= '0;
            cnt_lt  <= '0;
            cnt_err <= '0;
        end else if (clr) begin
            cnt_eq  <= '0;
            cnt_gt  <= '0;
            cnt_lt  <= '0;
            cnt_err <= '0;
        end else begin
            if (inc[0]) cnt_lt  <= cnt_lt + 1'b1;
            if (inc[1]) cnt_eq  <= cnt_eq + 1'b1;
            if (inc[2]) cnt_gt  <= cnt_gt + 1'b1;
            if (inc[3]) cnt_err <= cnt_err + 1'b1;
        end
    end

endmodule

// File: rtl/cmp_sweep_driver.sv
// cmp_sweep_driver: sweeps operand pairs onto a comparator, classifies its flags and streams result records
module cmp_sweep_driver #(
    parameter int DATA_W = cmp_pkg::DATA_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [DATA_W-1:0]   a_limit,
    input  logic [DATA_W-1:0]   b_limit,
    output logic [DATA_W-1:0]   din_a,
    output logic [DATA_W-1:0]   din_b,
    input  logic                comp_equal,
    input  logic                comp_greater,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [DATA_W-1:0]   res_a,
    output logic [DATA_W-1:0]   res_b,
    output logic [1:0]          res_code,
    output logic                busy,
    output logic                done,
    output logic [2*DATA_W:0]   cnt_eq,
    output logic [2*DATA_W:0]   cnt_gt,
    output logic [2*DATA_W:0]   cnt_lt,
    output logic [2*DATA_W:0]   cnt_err
);

    import cmp_pkg::*;

    localparam int CNT_W = 2 * DATA_W + 1;

    sweep_state_t      state, state_nx;
    logic [DATA_W-1:0] lim_a, lim_b;
    logic [1:0]        samp_code;
    logic              accept, last_b, last_a;
    logic [3:0]        inc;

    assign samp_code = classify(comp_equal, comp_greater);
    assign accept    = (state == S_IDLE) && start;
    assign last_b    = (din_b == lim_b);
    assign last_a    = (din_a == lim_a);
    assign inc       = (state == S_SAMPLE) ? (4'b0001 << samp_code) : 4'b0000;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    // Next-state and state-decoded handshake/status outputs
    always_comb begin
        state_nx  = state;
        res_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        case (state)
            S_IDLE:   if (start) state_nx = S_DRIVE;
            S_DRIVE:  begin busy = 1'b1; state_nx = S_SAMPLE; end
            S_SAMPLE: begin busy = 1'b1; state_nx = S_EMIT; end
            S_EMIT: begin
                busy      = 1'b1;
                res_valid = 1'b1;
                if (res_ready) state_nx = (last_a && last_b) ? S_DONE : S_DRIVE;
            end
            S_DONE:   begin done = 1'b1; state_nx = S_IDLE; end
            default:  state_nx = S_IDLE;
        endcase
    end

    // Operand stepping (B fastest, equality-terminated so all-ones limits never wrap) and record capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lim_a    <= '0;
            lim_b    <= '0;
            din_a    <= '0;
            din_b    <= '0;
            res_a    <= '0;
            res_b    <= '0;
            res_code <= '0;
        end else begin
            case (state)
                S_IDLE: if (start) begin
                    lim_a <= a_limit;
                    lim_b <= b_limit;
                    din_a <= '0;
                    din_b <= '0;
                end
                S_SAMPLE: begin
                    res_a    <= din_a;
                    res_b    <= din_b;
                    res_code <= samp_code;
                end
                S_EMIT: if (res_ready) begin
                    if (!last_b) begin
                        din_b <= din_b + 1'b1;
                    end else if (!last_a) begin
                        din_b <= '0;
                        din_a <= din_a + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    cmp_tally #(.CNT_W(CNT_W)) u_tally (
        .clk     (clk),
        .rst     (rst),
        .clr     (accept),
        .inc     (inc),
        .cnt_eq  (cnt_eq),
        .cnt_gt  (cnt_gt),
        .cnt_lt  (cnt_lt),
        .cnt_err (cnt_err)
    );

endmodule

// File: tb/tb_cmp_sweep_driver.sv
// tb_cmp_sweep_driver: scoreboard bench for the comparator sweep driver with a behavioural comparator
module tb_cmp_sweep_driver;

    localparam int DW = 8;
    localparam int CW = 2 * DW + 1;

    typedef struct packed {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [1:0]    c;
    } rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [DW-1:0] a_limit = '0;
    logic [DW-1:0] b_limit = '0;
    logic [DW-1:0] din_a, din_b;
    logic          comp_equal, comp_greater;
    logic          res_valid;
    logic          res_ready = 1'b1;
    logic [DW-1:0] res_a, res_b;
    logic [1:0]    res_code;
    logic          busy, done;
    logic [CW-1:0] cnt_eq, cnt_gt, cnt_lt, cnt_err;
    logic          fault_on = 1'b0;

    rec_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   nrec = 0;
    logic holding = 1'b0;
    rec_t held;

    always #5 clk = ~clk;

    // Behavioural comparator; the fault forces both flags on pair (1,1)
    assign comp_equal   = (fault_on && din_a == 8'd1 && din_b == 8'd1) ? 1'b1 : (din_a == din_b);
    assign comp_greater = (fault_on && din_a == 8'd1 && din_b == 8'd1) ? 1'b1 : (din_a > din_b);

    cmp_sweep_driver #(.DATA_W(DW)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .a_limit      (a_limit),
        .b_limit      (b_limit),
        .din_a        (din_a),
        .din_b        (din_b),
        .comp_equal   (comp_equal),
        .comp_greater (comp_greater),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_a        (res_a),
        .res_b        (res_b),
        .res_code     (res_code),
        .busy         (busy),
        .done         (done),
        .cnt_eq       (cnt_eq),
        .cnt_gt       (cnt_gt),
        .cnt_lt       (cnt_lt),
        .cnt_err      (cnt_err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, req);
        end
    endtask

    function automatic rec_t mk(input int a, input int b, input logic [1:0] c);
        rec_t r;
        r.a = a[DW-1:0];
        r.b = b[DW-1:0];
        r.c = c;
        return r;
    endfunction

    // Monitor: inputs change just after posedge, so at negedge valid&ready marks exactly one transfer
    always @(negedge clk) begin
        if (!rst && res_valid) begin
            if (holding) begin
                chk("stall_a", res_a, held.a);
                chk("stall_b", res_b, held.b);
                chk("stall_code", res_code, held.c);
            end
            if (res_ready) begin
                holding = 1'b0;
                nrec++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rec_extra: got (%0d,%0d) code %0d, expected no record", res_a, res_b, res_code);
                end else begin
                    rec_t e;
                    e = exp_q.pop_front();
                    chk("rec_a", res_a, e.a);
                    chk("rec_b", res_b, e.b);
                    chk("rec_code", res_code, e.c);
                end
            end else begin
                holding = 1'b1;
                held = mk(res_a, res_b, res_code);
            end
        end else begin
            holding = 1'b0;
        end
    end

    // Runs one sweep; exp_lat<0 skips the latency check, restart pulses a second start mid-sweep
    task automatic run_sweep(input int a, input int b, input int exp_lat, input int exp_recs,
                             input bit rnd, input bit restart);
        int cyc;
        int busy_n;
        cyc = 0;
        busy_n = 0;
        nrec = 0;
        @(posedge clk);
        #1;
        a_limit = a[DW-1:0];
        b_limit = b[DW-1:0];
        start = 1'b1;
        while (1) begin
            @(posedge clk);
            #1;
            start = 1'b0;
            cyc++;
            if (restart && cyc == 5) begin
                start = 1'b1;
                a_limit = 8'd3;
                b_limit = 8'd3;
            end
            if (restart && cyc == 9) a_limit = 8'd7;
            if (rnd) res_ready = 1'($urandom_range(0, 1));
            if (done || cyc >= 3000) break;
            if (busy) busy_n++;
        end
        chk("done_seen", done, 1);
        chk("busy_at_done", busy, 0);
        if (exp_lat >= 0) begin
            chk("done_latency", cyc - 1, exp_lat);
            chk("busy_cycles", busy_n, exp_lat);
        end
        @(posedge clk);
        #1;
        chk("done_one_cycle", done, 0);
        res_ready = 1'b1;
        chk("rec_count", nrec, exp_recs);
        chk("queue_empty", exp_q.size(), 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", res_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_din_a", din_a, 0);
        chk("rst_cnt_eq", cnt_eq, 0);
        rst = 1'b0;

        // Limits (1,1), ideal comparator
        exp_q.push_back(mk(0, 0, 2'b01));
        exp_q.push_back(mk(0, 1, 2'b00));
        exp_q.push_back(mk(1, 0, 2'b10));
        exp_q.push_back(mk(1, 1, 2'b01));
        run_sweep(1, 1, 12, 4, 1'b0, 1'b0);
        chk("c11_eq", cnt_eq, 2);
        chk("c11_gt", cnt_gt, 1);
        chk("c11_lt", cnt_lt, 1);
        chk("c11_err", cnt_err, 0);
        chk("c11_din_a_hold", din_a, 1);
        chk("c11_din_b_hold", din_b, 1);

        // Limits (0,0): a single record
        exp_q.push_back(mk(0, 0, 2'b01));
        run_sweep(0, 0, 3, 1, 1'b0, 1'b0);
        chk("c00_eq", cnt_eq, 1);
        chk("c00_lt", cnt_lt, 0);

        // Limits (2,3) with random backpressure
        for (int i = 0; i <= 2; i++)
            for (int j = 0; j <= 3; j++)
                exp_q.push_back(mk(i, j, (i == j) ? 2'b01 : (i > j) ? 2'b10 : 2'b00));
        run_sweep(2, 3, -1, 12, 1'b1, 1'b0);
        chk("c23_eq", cnt_eq, 3);
        chk("c23_gt", cnt_gt, 3);
        chk("c23_lt", cnt_lt, 6);

        // Faulty comparator on pair (1,1)
        fault_on = 1'b1;
        exp_q.push_back(mk(0, 0, 2'b01));
        exp_q.push_back(mk(0, 1, 2'b00));
        exp_q.push_back(mk(1, 0, 2'b10));
        exp_q.push_back(mk(1, 1, 2'b11));
        run_sweep(1, 1, 12, 4, 1'b0, 1'b0);
        chk("fault_err", cnt_err, 1);
        chk("fault_eq", cnt_eq, 1);
        fault_on = 1'b0;

        // Asynchronous reset while stalled in EMIT
        res_ready = 1'b0;
        @(posedge clk);
        #1;
        a_limit = 8'd2;
        b_limit = 8'd2;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        cyc = 0;
        while (!res_valid && cyc < 50) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("emit_reached", res_valid, 1);
        chk("emit_cnt_eq", cnt_eq, 1);
        #1;
        rst = 1'b1;
        #1;
        chk("arst_valid", res_valid, 0);
        chk("arst_busy", busy, 0);
        chk("arst_cnt_eq", cnt_eq, 0);
        chk("arst_din_b", din_b, 0);
        chk("arst_code", res_code, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        res_ready = 1'b1;
        exp_q.push_back(mk(0, 0, 2'b01));
        exp_q.push_back(mk(0, 1, 2'b00));
        run_sweep(0, 1, 6, 2, 1'b0, 1'b0);
        chk("post_rst_lt", cnt_lt, 1);

        // Second start while busy with different limits is ignored
        for (int i = 0; i <= 1; i++)
            for (int j = 0; j <= 2; j++)
                exp_q.push_back(mk(i, j, (i == j) ? 2'b01 : (i > j) ? 2'b10 : 2'b00));
        run_sweep(1, 2, 18, 6, 1'b0, 1'b1);
        chk("restart_total", cnt_eq + cnt_gt + cnt_lt + cnt_err, 6);
        chk("restart_din_a", din_a, 1);
        chk("restart_din_b", din_b, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
